// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared types and constants for the seg_scan_ctrl display scanner.
//   scan_state_t : scan FSM state (IDLE, BLANK, SHOW)
//   AN_OFF       : per-bit level that turns a common-anode digit off
//   max2()       : elaboration-time helper for sizing the slot counter
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Anodes are active-low, so a 1 on an anode pin keeps that digit dark.
  localparam logic AN_OFF = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value-producer / pin-side bundle of the display scanner.
//   enable, load, value, dp_in        : from the value producer (master) to the scanner
//   nibble, an_n, dp_n, pending,
//   frame_done                        : from the scanner (slave) back out
// Handshake: load is a single-cycle strobe with no ready/backpressure; the
// scanner accepts value/dp_in on every rising edge where load = 1, and a
// later strobe before the frame boundary simply replaces the earlier one.
// pending = 1 tells the producer a captured value is still waiting to be
// shown; frame_done pulses for one cycle on the edge a frame commits.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     an_n;
  logic                  dp_n;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output enable, load, value, dp_in,
    input  nibble, an_n, dp_n, pending, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in,
    output nibble, an_n, dp_n, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// scan_timer: loadable down-counter used to time BLANK and SHOW slots.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : slot length minus one
//   done       : counter has reached zero (last cycle of the slot)
// The counter stops at zero rather than wrapping, so done stays high until
// the next load.
module scan_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner for a common-anode 7-segment display.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : enable/load/value/dp_in in; nibble/an_n/dp_n/pending/frame_done out
//   state_dbg   : current scan FSM state
// Each digit gets BLANK_CYCLES dark cycles then DIV lit cycles. Loaded values
// sit in a shadow register and move to the display register only at the end
// of a full frame (or immediately while idle), so a frame never mixes values.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero
// digits (digit 0 always lit; a lit decimal point keeps its digit on).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_ctrl_if.slave    bus,
  output scan_state_t       state_dbg
);

  localparam int CW = $clog2(max2(DIV, BLANK_CYCLES) + 1);
  localparam int DW = $clog2(DIGITS);
  localparam logic [DW-1:0] LAST      = DW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_VAL = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_VAL  = CW'(DIV - 1);

  scan_state_t           state, state_nx;
  logic [DW-1:0]         digit, digit_nx;
  logic [4*DIGITS-1:0]   shadow_val, disp_val;
  logic [DIGITS-1:0]     shadow_dp, disp_dp;
  logic                  pending_q, frame_done_q;
  logic                  frame_end, commit;
  logic                  tmr_load, tmr_done;
  logic [CW-1:0]         tmr_val;
  logic                  lit_ok;
  logic [DIGITS-1:0]     an_n_c;
  logic [3:0]            nibble_c;
  logic                  dp_n_c;

  scan_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nx  = state;
    digit_nx  = digit;
    frame_end = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nx = BLANK;
          digit_nx = '0;
        end
      end
      BLANK: begin
        if (tmr_done) state_nx = SHOW;
      end
      SHOW: begin
        if (tmr_done) begin
          state_nx = BLANK;
          if (digit == LAST) begin
            digit_nx  = '0;
            frame_end = 1'b1;
          end else begin
            digit_nx = digit + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Dropping enable wins over everything, including a frame that was
    // about to complete; that pending value is then committed from IDLE.
    if (!bus.enable) begin
      state_nx  = IDLE;
      digit_nx  = '0;
      frame_end = 1'b0;
    end
    commit = frame_end || ((state == IDLE) && pending_q);
    // Reload on every state change; IDLE keeps the counter parked at zero.
    tmr_load = (state_nx != state) || (state == IDLE);
    case (state_nx)
      BLANK:   tmr_val = BLANK_VAL;
      SHOW:    tmr_val = SHOW_VAL;
      default: tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      digit        <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      digit        <= digit_nx;
      frame_done_q <= frame_end;
      // Commit reads the shadow before a same-cycle load overwrites it.
      if (commit) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
        pending_q  <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // upper_zero[i]: every nibble from digit i up to the top digit is zero.
  logic [DIGITS-1:0] upper_zero;
  for (genvar i = 0; i < DIGITS; i++) begin : g_uz
    assign upper_zero[i] = (disp_val[4*DIGITS-1:4*i] == '0);
  end
  assign lit_ok = (digit == '0) || !upper_zero[digit] || disp_dp[digit];
`else
  assign lit_ok = 1'b1;
`endif

  // Outputs decode registered state only; no input reaches a pin directly.
  always_comb begin
    an_n_c   = {DIGITS{AN_OFF}};
    dp_n_c   = 1'b1;
    nibble_c = 4'h0;
    if (state != IDLE) begin
      nibble_c = disp_val[{digit, 2'b00} +: 4];
      dp_n_c   = ~disp_dp[digit];
      if ((state == SHOW) && lit_ok) an_n_c[digit] = ~AN_OFF;
    end
  end

  assign bus.an_n       = an_n_c;
  assign bus.dp_n       = dp_n_c;
  assign bus.nibble     = nibble_c;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized + directed bench for seg_scan_ctrl
// (DIGITS=4, DIV=4, BLANK_CYCLES=1). The reference model tracks time since
// the scan started and derives digit/slot/lit purely arithmetically.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int SLOT   = BLANK + DIV;
  localparam int PER    = DIGITS * SLOT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  scan_state_t state_dbg;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  bit          m_run;
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend, m_fd;

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_disp = '0; m_shadow = '0;
    m_ddp = '0; m_sdp = '0; m_pend = 1'b0; m_fd = 1'b0;
  endfunction

  function automatic void model_edge(input logic en, input logic ld,
                                     input logic [15:0] v, input logic [3:0] d);
    bit commit = 0;
    m_fd = 1'b0;
    if (!m_run) begin
      commit = m_pend;
      if (en) begin m_run = 1; m_t = 0; end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_t++;
      if (m_t % PER == 0) begin commit = 1; m_fd = 1'b1; end
    end
    if (commit) begin m_disp = m_shadow; m_ddp = m_sdp; end
    if (ld) begin m_shadow = v; m_sdp = d; m_pend = 1'b1; end
    else if (commit) m_pend = 1'b0;
  endfunction

  // {an_n[3:0], dp_n, nibble[3:0], pending, frame_done, running}
  function automatic logic [11:0] model_out();
    logic [3:0] an;
    logic       dpn, lit;
    logic [3:0] nib;
    int         p, slot, off;
    an = 4'hF; dpn = 1'b1; nib = 4'h0;
    if (m_run) begin
      p    = m_t % PER;
      slot = p / SLOT;
      off  = p % SLOT;
      nib  = m_disp[4*slot +: 4];
      dpn  = ~m_ddp[slot];
      lit  = (off >= BLANK);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (m_disp >> (4*slot)) == 16'h0 && !m_ddp[slot]) lit = 1'b0;
`endif
      if (lit) an[slot] = 1'b0;
    end
    return {an, dpn, nib, m_pend, m_fd, m_run};
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;
  logic [11:0] act_v, exp_v;

  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {bus.an_n, bus.dp_n, bus.nibble, bus.pending, bus.frame_done,
               state_dbg != IDLE};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow @%0t: output seen with no expected entry", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL scan_out @%0t: got an_n=%b dp_n=%b nib=%h pend=%b fd=%b run=%b, required an_n=%b dp_n=%b nib=%h pend=%b fd=%b run=%b",
                   $time, act_v[11:8], act_v[7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                   exp_v[11:8], exp_v[7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic ld,
                      input logic [15:0] v, input logic [3:0] d);
    bus.enable = en; bus.load = ld; bus.value = v; bus.dp_in = d;
    @(posedge clk); #1;
    model_edge(en, ld, v, d);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Advance until the next edge lands on frame position pos.
  task automatic wait_pos(input int pos);
    int n = 0;
    while ((!m_run || ((m_t + 1) % PER != pos)) && n < 2*PER) begin
      step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
      n++;
    end
    if (n >= 2*PER) begin
      total++; bad++;
      $display("FAIL wait_pos: position %0d not reached within %0d cycles", pos, 2*PER);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(model_out());
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(model_out());
    bus.load = 1'b1; bus.value = 16'hC0DE; bus.dp_in = 4'hF;
    hold_reset(2);
    bus.load = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_r, ld_r;
    bus.enable = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    model_reset();
    @(posedge clk); #1;
    exp_q.push_back(model_out());
    mon_en = 1;
    hold_reset(2);
    rst_n = 1'b1;

    // Idle with enable low: dark display, nothing pending.
    run(8, 1'b0);
    // Load while idle commits on the following cycle.
    step(1'b0, 1'b1, 16'h3A51, 4'b0000);
    run(3, 1'b0);
    // Scan 3A51 for a bit over two frames.
    run(45, 1'b1);
    // Load FFFF during digit 1: current frame keeps A,3 on digits 2,3.
    wait_pos(6);
    step(1'b1, 1'b1, 16'hFFFF, 4'b0010);
    run(30, 1'b1);
    // Mid-frame load, then another load exactly on the commit edge.
    wait_pos(7);
    step(1'b1, 1'b1, 16'hBEEF, 4'b1000);
    wait_pos(0);
    step(1'b1, 1'b1, 16'h1234, 4'b0101);
    wait_pos(0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    run(5, 1'b1);
    // Drop enable in the middle of digit 2's SHOW, then re-enable.
    wait_pos(12);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    run(4, 1'b0);
    run(30, 1'b1);
    // Drop enable with a load pending: IDLE commit path.
    wait_pos(9);
    step(1'b1, 1'b1, 16'h9876, 4'b0001);
    run(3, 1'b0);
    run(10, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en_r = ($urandom_range(0, 24) != 0);
      ld_r = ($urandom_range(0, 11) == 0);
      step(en_r, ld_r, 16'($urandom), 4'($urandom));
    end

    // Reset in the middle of a frame with data pending.
    run(20, 1'b1);
    step(1'b1, 1'b1, 16'h5555, 4'hA);
    run(3, 1'b1);
    mid_reset();
    run(25, 1'b1);

    // Leading-zero scenarios (all digits lit in the default build).
    step(1'b1, 1'b1, 16'h0007, 4'b0000);
    run(45, 1'b1);
    step(1'b1, 1'b1, 16'h0007, 4'b0100);
    run(45, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 4'b0000);
    run(45, 1'b1);

    @(negedge clk); #1;
    mon_en = 0;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It owns the shared hex-to-segment decoder: each digit is selected in turn, its nibble is presented to the decoder, and the matching active-low anode is driven. The block sits between the value-producing logic and the board pins. New values are double-buffered and committed only at frame boundaries, so no frame ever shows a mix of old and new digits.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- DIV, 50000, clock cycles each digit is lit per visit (≥1)
- BLANK_CYCLES, 2, cycles with all anodes off before each digit (≥1, anti-ghosting)
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scan running; 0 = display dark
- load  in  1  single-cycle strobe: capture value/dp_in into shadow
- value  in  4*DIGITS  hex nibbles; digit 0 = bits [3:0] (least significant)
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
- nibble  out  4  nibble of the currently selected digit, to decoder input
- an_n  out  DIGITS  active-low digit enables; at most one bit is 0
- dp_n  out  1  active-low decimal point for the selected digit
- pending  out  1  shadow holds an uncommitted value
- frame_done  out  1  one-cycle pulse at the end of each complete frame

## Operation
- Registers: shadow (value, dp), display (value, dp), digit index (0..DIGITS-1), cycle counter, state.
- FSM states:
  - IDLE: an_n all 1, dp_n = 1. Entered on reset or whenever enable = 0.
  - BLANK: an_n all 1. Lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: an_n[digit] = 0. Lasts DIV cycles, then goes to BLANK with digit+1; the index wraps from DIGITS-1 to 0.
- IDLE→BLANK with digit = 0 on the cycle enable is sampled 1.
- enable = 0 in any state: next cycle is IDLE, digit = 0, counter = 0.
- nibble = display[4*digit +: 4] and dp_n = ~display_dp[digit] in BLANK/SHOW. In IDLE, nibble = 0.
- Load: load = 1 gives shadow ← value/dp_in and pending ← 1 on the next edge. A later load before commit overwrites the shadow (latest wins).
- Commit (display ← shadow, pending ← 0) happens on either of:
  - the SHOW→BLANK transition of digit DIGITS-1; frame_done pulses on that same cycle;
  - any cycle in IDLE while pending = 1.
- Load and commit on the same cycle: the old shadow is committed, the new value lands in the shadow, and pending stays 1.
- Counter width is $clog2(max(DIV, BLANK_CYCLES)+1). The counter restarts at 0 on every state change.

## Timing
- Reset values: an_n = all 1, dp_n = 1, nibble = 0, pending = 0, frame_done = 0. Internal state: IDLE, digit = 0, display = 0, shadow = 0.
- Outputs are registered (state-decoded from registers); no combinational path from any input to any output.
- Frame period = DIGITS*(BLANK_CYCLES+DIV) cycles. The first anode asserts BLANK_CYCLES+1 cycles after enable rises.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). Loaded and pending data are lost.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: during SHOW of digit i > 0, an_n stays all 1 if display nibbles i..DIGITS-1 are all zero and display_dp[i] = 0. Digit 0 is always lit.
- Not defined: every digit is lit during its SHOW slot.
- The FSM, timing and frame period are identical in both cases.

## Structure
- Package seg_pkg: scan state enum (IDLE, BLANK, SHOW) and the anode-off constant.
- Sub-module scan_timer: loadable down-counter with a done flag, parameterised by width. It is instantiated once and reloaded with DIV or BLANK_CYCLES on each state change.

## Test plan
All scenarios use DIGITS=4, DIV=4, BLANK_CYCLES=1.
- Reset, enable=0 → an_n=4'b1111, dp_n=1, nibble=0, pending=0 held indefinitely.
- load value=16'h3A51, enable=1 → pending falls 1 cycle after the load (IDLE commit). an_n sequence 1110,1101,1011,0111, each low 4 cycles with 1 blank cycle between. nibble 1,5,A,3. frame_done pulses every 20 cycles.
- While scanning, load 16'hFFFF at digit 1 → digits 2 and 3 still show A,3. FFFF appears from the next frame; pending drops on the frame_done cycle.
- load on the exact frame_done cycle → the old shadow is committed, pending stays 1, and the new value is committed at the following frame_done.
- enable dropped mid-SHOW of digit 2 → next cycle an_n=1111. Re-enable → digit 0 lit 2 cycles after enable rises.
- With SEG_LEADING_ZERO_BLANK_EN, value=16'h0007, dp_in=0 → only digit 0 ever lit, frame period still 20 cycles. With dp_in=4'b0100 → digits 0 and 2 lit.
